// File: rtl/crossing_request_scheduler_pkg.sv
// Shared types and constants for the crossing request front-end.
// Timing defaults are also used by the crosswalk timers.
package crossing_request_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_IDLE,
        S_HOLDOFF
    } state_t;

    typedef enum logic {
        REQ_PED = 1'b0,
        REQ_VEH = 1'b1
    } req_t;

    // Lamp order {PR, PG, RR, RG, RY}: both reds on, nothing else.
    localparam logic [4:0] IDLE_LAMPS = 5'b10100;

    localparam int DEF_DB_CYCLES = 1000;
    localparam int DEF_HOLDOFF   = 2000;
    localparam int DEF_ISSUE_TO  = 16;
    localparam int DEF_CNT_W     = 16;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/crossing_request_scheduler_input_debouncer.sv
// Two-flop synchronizer plus stability counter for one raw input.
// rise pulses for one cycle as the debounced level goes high.
module input_debouncer
    import crossing_request_scheduler_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    // High pulse on the cycle the debounced level flips from 0 to 1.
    assign rise = s2 & ~level & (cnt == LAST);

    // Synchronize, then let the level follow only a long-stable input.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossing_request_scheduler.sv
// Latches debounced pedestrian/vehicle requests and issues them
// one at a time to the crosswalk, with timeout and hold-off.
module crossing_request_scheduler
    import crossing_request_scheduler_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int HOLDOFF   = DEF_HOLDOFF,
    parameter int ISSUE_TO  = DEF_ISSUE_TO,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_RAW,
    input  logic             SNS_RAW,
    input  logic             PR,
    input  logic             PG,
    input  logic             RR,
    input  logic             RG,
    input  logic             RY,
    output logic             BUTTON,
    output logic             SENSOR,
    output logic             PED_WAIT,
    output logic             VEH_WAIT,
    output logic             FAULT,
    output logic [CNT_W-1:0] SERVED_CNT
);

    localparam int TW = $clog2(max2(HOLDOFF, ISSUE_TO) + 2);

    state_t        state;
    req_t          sel;
    req_t          last_served;
    req_t          pick;
    logic [TW-1:0] tmr;
    logic          ped_rise;
    logic          veh_rise;
    logic          ped_pend;
    logic          veh_pend;
    logic          lamp_idle;
    logic          go;
    logic          clr_ped;
    logic          clr_veh;

    input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_btn_db (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (BTN_RAW),
        .rise (ped_rise)
    );

    input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_sns_db (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (SNS_RAW),
        .rise (veh_rise)
    );

    assign lamp_idle = ({PR, PG, RR, RG, RY} == IDLE_LAMPS);
    assign go        = (state == S_IDLE) && lamp_idle && (ped_pend || veh_pend);
    assign clr_ped   = go && (pick == REQ_PED);
    assign clr_veh   = go && (pick == REQ_VEH);
    assign PED_WAIT  = ped_pend;
    assign VEH_WAIT  = veh_pend;

    // Alternate when both wait, else take whichever one is pending.
    always_comb begin
        pick = REQ_VEH;
        if (ped_pend && veh_pend) begin
            pick = (last_served == REQ_VEH) ? REQ_PED : REQ_VEH;
        end else if (ped_pend) begin
            pick = REQ_PED;
        end
    end

    // Sticky pending latches; a new edge wins over the issue clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ped_pend <= 1'b0;
            veh_pend <= 1'b0;
        end else begin
            ped_pend <= (ped_pend & ~clr_ped) | ped_rise;
            veh_pend <= (veh_pend & ~clr_veh) | veh_rise;
        end
    end

    // Issue/service/hold-off sequencer with registered request outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            sel         <= REQ_PED;
            last_served <= REQ_VEH;
            tmr         <= '0;
            BUTTON      <= 1'b0;
            SENSOR      <= 1'b0;
            FAULT       <= 1'b0;
            SERVED_CNT  <= '0;
        end else begin
            BUTTON <= 1'b0;
            SENSOR <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state <= S_ISSUE;
                        sel   <= pick;
                        tmr   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!lamp_idle) begin
                        state <= S_WAIT_IDLE;
                    end else if (tmr == TW'(ISSUE_TO)) begin
                        FAULT <= 1'b1;
                        state <= S_HOLDOFF;
                        tmr   <= '0;
                    end else begin
                        BUTTON <= (sel == REQ_PED);
                        SENSOR <= (sel == REQ_VEH);
                        tmr    <= tmr + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (lamp_idle) begin
                        SERVED_CNT  <= SERVED_CNT + 1'b1;
                        last_served <= sel;
                        state       <= S_HOLDOFF;
                        tmr         <= '0;
                    end
                end
                S_HOLDOFF: begin
                    if (int'(tmr) + 1 >= HOLDOFF) begin
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
